// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN       : instruction word width
//   IADDR_W    : instruction memory byte-address width
//   INST_STEP  : byte distance between consecutive instruction words
//   INST_NOP   : canonical NOP encoding (addi x0, x0, 0), used by decode
//   fetch_entry_t : one queue entry, fetched word plus its byte address
package inst_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int IADDR_W = 8;

    localparam logic [IADDR_W-1:0] INST_STEP = IADDR_W'(4);
    localparam logic [XLEN-1:0]    INST_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    instr;
        logic [IADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {instruction, pc} pairs.
// Entry 0 is always the head, so the output needs no read pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : enqueue din (accepted when not full, or full with a pop)
//   pop        : dequeue head (ignored when empty)
//   flush      : clear all entries; wins over push and pop
//   din        : entry to enqueue
//   dout       : head entry, all zeros when empty
//   full/empty : occupancy flags
module fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   count;
    logic         pop_ok;
    logic         push_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_ok  = pop && !empty;
    // A full queue can still take a word when the head leaves this cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    slot1 <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit. Drives the byte address of a combinational
// instruction memory, buffers returned words in a 2-entry queue and
// hands them to decode over valid/ready. A redirect flushes the queue
// and restarts fetch at the (word-aligned) target.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : fetch byte address (always word aligned)
//   imem_instr      : memory read data for imem_addr, same cycle
//   redirect_valid  : one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc     : redirect target, low two bits ignored
//   inst_valid      : queue head valid
//   inst_ready      : decode takes the head this cycle
//   inst_data       : head instruction, 0 when empty
//   inst_pc         : head byte address, 0 when empty
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_instr,
    input  logic               redirect_valid,
    input  logic [IADDR_W-1:0] redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst_data,
    output logic [IADDR_W-1:0] inst_pc
);

    logic [IADDR_W-1:0] fpc;
    logic [IADDR_W-1:0] redirect_target;
    logic               q_full;
    logic               q_empty;
    logic               pop;
    logic               push;
    fetch_entry_t       q_din;
    fetch_entry_t       q_dout;

    assign redirect_target = redirect_pc & ~IADDR_W'(3);

    assign pop  = inst_valid && inst_ready;
    // Fetching while a redirect is in flight would enqueue a stale word.
    assign push = !redirect_valid && (!q_full || pop);

    assign q_din = '{instr: imem_instr, pc: fpc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc <= RESET_PC;
        end else if (redirect_valid) begin
            fpc <= redirect_target;
        end else if (push) begin
            fpc <= fpc + INST_STEP;
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_addr  = fpc;
    assign inst_valid = !q_empty;
    assign inst_data  = q_dout.instr;
    assign inst_pc    = q_dout.pc;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that drives the 8-bit byte address of the instruction memory and consumes its combinational 32-bit read data. It holds the fetch PC, buffers fetched words in a 2-entry queue, and presents them to decode over a valid/ready handshake. Redirects (branch/jump) flush the queue and restart fetch at the new target.

## Interface
- `RESET_PC`, default 8'h00: fetch address after reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_addr`  out  8  byte address to instruction memory; bits [1:0] are always 0.
- `imem_instr`  in  32  instruction word for `imem_addr`, valid in the same cycle (combinational memory).
- `redirect_valid`  in  1  one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc`  in  8  redirect target; bits [1:0] ignored.
- `inst_valid`  out  1  queue head holds a valid instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst_data`  out  32  instruction at the queue head; 0 when empty.
- `inst_pc`  out  8  byte address of `inst_data`; 0 when empty.

## Operation
- Fetch PC register `fpc` drives `imem_addr` directly.
- Push condition: queue not full, or queue full and a pop occurs this cycle. No push in a redirect cycle.
- On push: enqueue {`imem_instr`, `fpc`} and set `fpc` to `fpc + 4` modulo 256, so 0xFC wraps to 0x00.
- Pop: `inst_valid && inst_ready`. The head is removed at the clock edge.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved.
- Redirect has priority over everything else:
  - The queue is cleared.
  - `fpc <= {redirect_pc[7:2], 2'b00}`.
  - A handshake completing in the redirect cycle still counts as consumed by decode.
- The queue never drops, duplicates or reorders entries outside a redirect.
- The block has no terminal state; fetch runs continuously.

## Timing
- Reset values: `fpc` = `RESET_PC`, queue empty, `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0.
- Reset effect: assertion of `rst_n` takes effect immediately, without waiting for a clock edge. This includes mid-stream.
- Latency from `imem_addr` to `inst_valid` is 1 cycle:
  - The first instruction appears one edge after reset release.
  - It also appears one edge after a redirect edge.
- The cycle immediately following a redirect edge shows `inst_valid` = 0.
- Throughput is 1 instruction per cycle with `inst_ready` held high, with no bubbles.
- Backpressure: with `inst_ready` low, the queue fills in 2 cycles. `fpc` then holds at head PC + 8, and `imem_addr` stays stable while full.
- All outputs are driven from registers or the queue. No combinational path from `inst_ready` or `redirect_*` to outputs, except the queue-full push decision that gates `fpc`.

## Structure
- Shared package holds:
  - `XLEN` = 32 and `IADDR_W` = 8.
  - The instruction word step constant (4).
  - The NOP encoding 32'h00000013, for decode-side use.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO (40-bit entries: instruction + PC) with push/pop/flush and full/empty. Flush has priority over push.
- Top level contains only `fpc`, the push/redirect logic and output wiring.

## Test plan
- Reset release, `inst_ready` = 1, program memory loaded: consecutive cycles show (pc, data) = (0x00, 0x00007033), (0x04, 0x00100093), (0x08, 0x00200113), with no gaps.
- `inst_ready` = 0 for 5 cycles after reset:
  - During the stall: `inst_valid` = 1, `inst_pc` holds 0x00, `imem_addr` settles at 0x08.
  - After `inst_ready` rises: 0x00, 0x04, 0x08, 0x0C appear back-to-back, with no duplicates or skips.
- `redirect_valid` pulse with `redirect_pc` = 0x48 while streaming:
  - Next cycle: `inst_valid` = 0.
  - Then (0x48, 0x02b02823), then (0x4C, 0x03002603).
  - Stale entries never appear.
- `redirect_pc` = 0x4B, misaligned: fetch resumes at 0x48, and `imem_addr[1:0]` is always 0.
- Redirect to 0xFC: (0xFC, mem[63]) is followed by (0x00, 0x00007033), showing wrap-around.
- `rst_n` pulsed low between clock edges mid-stream with the queue full:
  - Immediately: `inst_valid` = 0 and `imem_addr` = `RESET_PC`.
  - After release: the stream restarts at 0x00.
